// File: rtl/rf_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rf_wr_arb
// Purpose  : Register-file write-port arbiter. The in-order WB stage always
//            owns the write port when it writes a non-x0 register. Results
//            from the long-latency unit queue in a small FIFO and drain into
//            cycles WB leaves free. A starvation counter raises stall_req
//            when the FIFO head has been blocked for STARVE_MAX cycles so
//            the pipeline can open a WB slot.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            wb_rf_bus[37:0] - {we, waddr[4:0], wdata[31:0]} from WB
//            lu_valid/lu_ready/lu_waddr/lu_wdata - long-latency result in
//            rf_bus[37:0]   - {we, waddr, wdata} to the RF write port
//            stall_req      - ask the stall controller for a WB bubble
//            lu_pend[3:0]   - occupied FIFO entries
// Config   : RF_WR_ARB_BYPASS_EN - when defined, a result arriving while the
//            FIFO is empty and the port is free is written in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wr_arb #(
    parameter int FIFO_DEPTH = 2,   // power of two, 2..8
    parameter int STARVE_MAX = 4    // 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] wb_rf_bus,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic [37:0] rf_bus,
    output logic        stall_req,
    output logic [3:0]  lu_pend
);

    localparam int              c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [3:0]      c_DEPTH   = 4'(FIFO_DEPTH);
    localparam logic [3:0]      c_SMAX    = 4'(STARVE_MAX);

    logic [4:0]         r_mem_addr [FIFO_DEPTH];
    logic [31:0]        r_mem_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [3:0]         r_count;
    logic [3:0]         r_starve;

    logic w_wb_claim;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_bypass;

    // WB writes to x0 are architecturally dead, so they do not hold the port.
    assign w_wb_claim = wb_rf_bus[37] && (wb_rf_bus[36:32] != 5'd0);
    assign w_empty    = (r_count == 4'd0);

    // Readiness depends only on the registered occupancy: a pop in the same
    // cycle never frees a slot for a simultaneous push.
    assign lu_ready   = !rst && (r_count != c_DEPTH);

    assign w_pop      = !rst && !w_wb_claim && !w_empty;

`ifdef RF_WR_ARB_BYPASS_EN
    assign w_bypass   = !rst && !w_wb_claim && w_empty && lu_valid && (lu_waddr != 5'd0);
`else
    assign w_bypass   = 1'b0;
`endif

    // Results for x0 are accepted by the handshake but never stored.
    assign w_push     = lu_valid && lu_ready && (lu_waddr != 5'd0) && !w_bypass;

    // Write-port mux: WB first, then FIFO head, then (optionally) bypass.
    always_comb begin
        rf_bus = '0;
        if (!rst) begin
            if (w_wb_claim) begin
                rf_bus = wb_rf_bus;
            end else if (!w_empty) begin
                rf_bus = {1'b1, r_mem_addr[r_rd_ptr], r_mem_data[r_rd_ptr]};
            end else if (w_bypass) begin
                rf_bus = {1'b1, lu_waddr, lu_wdata};
            end
        end
    end

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= lu_waddr;
            r_mem_data[r_wr_ptr] <= lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts blocked cycles of a valid head; a freshly pushed entry only
    // becomes the head in the following cycle, so an empty FIFO holds zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else if (w_empty || w_pop) begin
            r_starve <= 4'd0;
        end else if (r_starve != c_SMAX) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    assign stall_req = (r_starve == c_SMAX);
    assign lu_pend   = r_count;

endmodule
`default_nettype wire
